// File: rtl/pio_irq_pkg.sv
// Shared types and constants for the PIO irq sequencer.
package pio_irq_pkg;

    // Sequencer FSM states.
    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StArb,
        StRd,
        StRdWait,
        StClr,
        StPush
    } state_e;

    // Word offsets of the PIO slave registers.
    localparam logic [1:0] OFF_DATA = 2'd0;
    localparam logic [1:0] OFF_MASK = 2'd2;
    localparam logic [1:0] OFF_EDGE = 2'd3;

    // Ceiling log2; returns 0 for values 0 and 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pio_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping.
module pio_rr_arbiter #(
    parameter int unsigned N_PIO = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N_PIO-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] win_o,
    output logic             any_o
);

    logic [IDX_W:0] j;
    logic           found;

    // Scan N_PIO positions starting at the pointer; the first hit wins.
    always_comb begin
        win_o = '0;
        found = 1'b0;
        j     = '0;
        for (int unsigned k = 0; k < N_PIO; k++) begin
            j = {1'b0, ptr_i} + (IDX_W + 1)'(k);
            if (j >= (IDX_W + 1)'(N_PIO)) begin
                j = j - (IDX_W + 1)'(N_PIO);
            end
            if (!found && req_i[j[IDX_W-1:0]]) begin
                found = 1'b1;
                win_o = j[IDX_W-1:0];
            end
        end
        any_o = |req_i;
    end

endmodule

// File: rtl/pio_irq_sequencer.sv
// Avalon-MM master: programs PIO irq masks after reset, then services edge-capture irqs
// round-robin and emits one event per non-zero capture.
// Optional feature macro: PIO_IRQ_TIMESTAMP_EN adds evt_time from a free-running counter.
module pio_irq_sequencer
    import pio_irq_pkg::*;
#(
    parameter int unsigned N_PIO        = 4,
    parameter int unsigned READ_LATENCY = 1,
    parameter logic [31:0] INIT_MASK    = 32'd1,
    localparam int unsigned IDX_W       = (clog2(N_PIO) >= 1) ? clog2(N_PIO) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_PIO-1:0] irq_in,
    output logic [IDX_W+1:0] avm_address,
    output logic             avm_read,
    output logic             avm_write,
    output logic [31:0]      avm_writedata,
    input  logic [31:0]      avm_readdata,
    input  logic             avm_waitrequest,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [IDX_W-1:0] evt_index,
    output logic [31:0]      evt_data,
    output logic             init_done
`ifdef PIO_IRQ_TIMESTAMP_EN
    ,
    output logic [31:0]      evt_time
`endif
);

    localparam logic [2:0] LAT_LAST = 3'(READ_LATENCY - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] init_idx_q, init_idx_d;
    logic [IDX_W-1:0] win_q, win_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [2:0]       lat_cnt_q, lat_cnt_d;
    logic [31:0]      data_q, data_d;
    logic [IDX_W+1:0] addr_q, addr_d;
    logic             read_q, read_d;
    logic             write_q, write_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;

    logic [IDX_W-1:0] arb_win;
    logic             arb_any;
    logic [IDX_W-1:0] ptr_nxt;
    logic [IDX_W-1:0] init_nxt;

    pio_rr_arbiter #(
        .N_PIO (N_PIO),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_i (irq_in),
        .ptr_i (ptr_q),
        .win_o (arb_win),
        .any_o (arb_any)
    );

    assign ptr_nxt  = (win_q == IDX_W'(N_PIO - 1)) ? '0 : win_q + IDX_W'(1);
    assign init_nxt = init_idx_q + IDX_W'(1);

    // Next-state logic; bus requests are registered so every output is 0 during reset.
    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        win_d      = win_q;
        ptr_d      = ptr_q;
        lat_cnt_d  = lat_cnt_q;
        data_d     = data_q;
        addr_d     = addr_q;
        read_d     = read_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        valid_d    = valid_q;
        done_d     = done_q;
        unique case (state_q)
            StInit: begin
                if (!write_q) begin
                    write_d = 1'b1;
                    addr_d  = {init_idx_q, OFF_MASK};
                    wdata_d = INIT_MASK;
                end else if (!avm_waitrequest) begin
                    if (init_idx_q == IDX_W'(N_PIO - 1)) begin
                        write_d = 1'b0;
                        addr_d  = '0;
                        wdata_d = '0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        init_idx_d = init_nxt;
                        addr_d     = {init_nxt, OFF_MASK};
                    end
                end
            end
            StIdle: begin
                if (|irq_in) state_d = StArb;
            end
            StArb: begin
                // irq may have dropped since IDLE saw it.
                if (arb_any) begin
                    win_d   = arb_win;
                    read_d  = 1'b1;
                    addr_d  = {arb_win, OFF_EDGE};
                    state_d = StRd;
                end else begin
                    state_d = StIdle;
                end
            end
            StRd: begin
                if (!avm_waitrequest) begin
                    read_d    = 1'b0;
                    addr_d    = '0;
                    lat_cnt_d = '0;
                    state_d   = StRdWait;
                end
            end
            StRdWait: begin
                if (lat_cnt_q == LAT_LAST) begin
                    if (avm_readdata != '0) begin
                        data_d  = avm_readdata;
                        write_d = 1'b1;
                        addr_d  = {win_q, OFF_EDGE};
                        wdata_d = '0;
                        state_d = StClr;
                    end else begin
                        // Spurious irq: nothing to clear or report, but still rotate.
                        ptr_d   = ptr_nxt;
                        state_d = StIdle;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q + 3'd1;
                end
            end
            StClr: begin
                if (!avm_waitrequest) begin
                    write_d = 1'b0;
                    addr_d  = '0;
                    valid_d = 1'b1;
                    state_d = StPush;
                end
            end
            StPush: begin
                if (evt_ready) begin
                    valid_d = 1'b0;
                    ptr_d   = ptr_nxt;
                    state_d = StIdle;
                end
            end
            default: state_d = StInit;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StInit;
            init_idx_q <= '0;
            win_q      <= '0;
            ptr_q      <= '0;
            lat_cnt_q  <= '0;
            data_q     <= '0;
            addr_q     <= '0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
            win_q      <= win_d;
            ptr_q      <= ptr_d;
            lat_cnt_q  <= lat_cnt_d;
            data_q     <= data_d;
            addr_q     <= addr_d;
            read_q     <= read_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
        end
    end

    assign avm_address   = addr_q;
    assign avm_read      = read_q;
    assign avm_write     = write_q;
    assign avm_writedata = wdata_q;
    assign evt_valid     = valid_q;
    assign evt_index     = win_q;
    assign evt_data      = data_q;
    assign init_done     = done_q;

`ifdef PIO_IRQ_TIMESTAMP_EN
    logic [31:0] ts_q, ts_d;
    logic [31:0] ts_lat_q, ts_lat_d;

    // Free-running cycle counter, sampled when the winner is latched.
    always_comb begin
        ts_d     = ts_q + 32'd1;
        ts_lat_d = ts_lat_q;
        if (state_q == StArb && arb_any) ts_lat_d = ts_q;
    end

    // Timestamp registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ts_q     <= '0;
            ts_lat_q <= '0;
        end else begin
            ts_q     <= ts_d;
            ts_lat_q <= ts_lat_d;
        end
    end

    assign evt_time = ts_lat_q;
`endif

endmodule
